chaos_code_gen: RTL



---
 rtl/chaos_code_pkg.sv | 44 ++++
 rtl/chaos_code_gen_arx_round.sv | 25 ++
 rtl/chaos_code_gen.sv | 118 +++++++++++
 3 files changed

// File: rtl/chaos_code_pkg.sv
// Shared types and constants for the ARX chaotic keystream generator.
// Holds the state bundle, FSM encoding and the rotate/seed helpers.
package chaos_code_pkg;

   localparam logic [31:0] GOLDEN = 32'h9E3779B9;

   localparam int R0 = 7;
   localparam int R1 = 9;
   localparam int R2 = 13;
   localparam int R3 = 18;

   typedef enum logic [1:0] {
      UNSEEDED,
      RUN,
      LATCH,
      READY
   } chaos_fsm_e;

   typedef struct packed {
      logic [31:0] x;
      logic [31:0] y;
      logic [31:0] z;
      logic [31:0] w;
   } chaos_state_t;

   function automatic logic [31:0] rotl(
      input logic [31:0] v,
      input int          n
   );
      return (v << n) | (v >> (32 - n));
   endfunction

   function automatic chaos_state_t seed_state(
      input logic [31:0] key
   );
      chaos_state_t s;
      s.x = key;
      s.y = rotl(key, 8);
      s.z = ~key;
      s.w = key ^ GOLDEN;
      return s;
   endfunction

endpackage

// File: rtl/chaos_code_gen_arx_round.sv
// One combinational ARX map iteration; each lane feeds the next.
// Lanes are evaluated in order x, y, z, w using the freshly updated values.
module chaos_code_gen_arx_round
   import chaos_code_pkg::*;
(
   input  chaos_state_t i_state,
   output chaos_state_t o_state
);

   logic [31:0] w_x;
   logic [31:0] w_y;
   logic [31:0] w_z;
   logic [31:0] w_w;

   assign w_x = (i_state.x + rotl(i_state.w, R0)) ^ i_state.y;
   assign w_y = (i_state.y + rotl(w_x, R1)) ^ i_state.z;
   assign w_z = (i_state.z + rotl(w_y, R2)) ^ i_state.w;
   assign w_w = (i_state.w + rotl(w_z, R3)) ^ w_x;

   assign o_state.x = w_x;
   assign o_state.y = w_y;
   assign o_state.z = w_z;
   assign o_state.w = w_w;

endmodule

// File: rtl/chaos_code_gen.sv
// Chaotic keystream source: seeds from a 32-bit key, runs ARX rounds
// per software step and presents four key bytes with a done flag.
module chaos_code_gen
   import chaos_code_pkg::*;
#(
   parameter int ROUNDS = 4,
   parameter int WARMUP = 16
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        chaos_step,
   input  logic        chaos_reset,
   input  logic [31:0] chaos_shift,
   output logic        chaos_done,
   output logic [7:0]  chaos_x,
   output logic [7:0]  chaos_y,
   output logic [7:0]  chaos_z,
   output logic [7:0]  chaos_w
);

   localparam logic [7:0] C_ROUNDS = 8'(ROUNDS);
   localparam logic [7:0] C_WARMUP = 8'(WARMUP);

   chaos_fsm_e   r_fsm;
   chaos_fsm_e   w_fsm_nxt;
   chaos_state_t r_st;
   chaos_state_t w_st_nxt;
   chaos_state_t w_round;
   logic [7:0]   r_cnt;
   logic [7:0]   w_cnt_nxt;
   logic         r_done;
   logic         w_done_nxt;
   logic [31:0]  r_key;
   logic [31:0]  w_key_nxt;
   logic         r_step_d;
   logic         r_rst_d;
   logic         w_step_edge;
   logic         w_seed_edge;

   assign w_step_edge = chaos_step & ~r_step_d;
   assign w_seed_edge = chaos_reset & ~r_rst_d;

   chaos_code_gen_arx_round u_round (
      .i_state (r_st),
      .o_state (w_round)
   );

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_fsm    <= UNSEEDED;
         r_st     <= '0;
         r_cnt    <= '0;
         r_done   <= 1'b0;
         r_key    <= '0;
         r_step_d <= 1'b0;
         r_rst_d  <= 1'b0;
      end else begin
         r_fsm    <= w_fsm_nxt;
         r_st     <= w_st_nxt;
         r_cnt    <= w_cnt_nxt;
         r_done   <= w_done_nxt;
         r_key    <= w_key_nxt;
         r_step_d <= chaos_step;
         r_rst_d  <= chaos_reset;
      end
   end

   // A reseed pre-empts everything, including a run in progress.
   always_comb begin
      w_fsm_nxt  = r_fsm;
      w_st_nxt   = r_st;
      w_cnt_nxt  = r_cnt;
      w_done_nxt = r_done;
      w_key_nxt  = r_key;
      if (w_seed_edge) begin
         w_st_nxt   = seed_state(chaos_shift);
         w_cnt_nxt  = C_WARMUP;
         w_done_nxt = 1'b0;
         w_fsm_nxt  = RUN;
      end else begin
         unique case (r_fsm)
            UNSEEDED: begin
               w_fsm_nxt = UNSEEDED;
            end
            RUN: begin
               w_st_nxt  = w_round;
               w_cnt_nxt = r_cnt - 8'd1;
               if (r_cnt <= 8'd1) begin
                  w_fsm_nxt = LATCH;
               end
            end
            LATCH: begin
               w_key_nxt  = {r_st.x[31:24], r_st.y[31:24],
                             r_st.z[31:24], r_st.w[31:24]};
               w_done_nxt = 1'b1;
               w_fsm_nxt  = READY;
            end
            READY: begin
               if (w_step_edge) begin
                  w_done_nxt = 1'b0;
                  w_cnt_nxt  = C_ROUNDS;
                  w_fsm_nxt  = RUN;
               end
            end
            default: begin
               w_fsm_nxt = UNSEEDED;
            end
         endcase
      end
   end

   assign chaos_done = r_done;
   assign chaos_x    = r_key[31:24];
   assign chaos_y    = r_key[23:16];
   assign chaos_z    = r_key[15:8];
   assign chaos_w    = r_key[7:0];

endmodule
